// File: rtl/jam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jam_pkg
// Purpose  : Shared widths, constants and FSM state encoding for the
//            job-assignment (JAM) scheduler and its sub-blocks.
// Contents : N_IDX, IDX_W, COST_W, SUM_W, CNT_W, WD_W, TIMEOUT_CYC,
//            MAX_COST, state_t (3-bit LOAD/DRAIN/START/WAIT/DONE)
// Config   : TIMEOUT_CYC / WD_W are only consumed when JAM_TIMEOUT_EN is set
// Revision : 1.0 - initial release
// ============================================================================
package jam_pkg;

  localparam int N_IDX       = 8;
  localparam int IDX_W       = $clog2(N_IDX);
  localparam int COST_W      = 7;
  localparam int SUM_W       = 10;
  localparam int CNT_W       = 4;
  localparam int WD_W        = 16;
  localparam int TIMEOUT_CYC = 40400;   // must exceed 8! = 40320 sweep cycles

  localparam logic [SUM_W-1:0] MAX_COST = SUM_W'(1023);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_DRAIN = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/jam_eval_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : jam_eval_scheduler_if
// Purpose  : Bundles the cost-ROM address/data, evaluator write/start/done
//            handshake and the latched result outputs of the scheduler.
// Modports : master - scheduler side (drives W/J, ev_*, results)
//            slave  - environment side (ROM, evaluator, result consumer)
// Signals  : W, J, Cost, Restart, ev_wr_en, ev_wr_w, ev_wr_j, ev_wr_data,
//            ev_start, ev_done, ev_min, ev_cnt, MinCost, MatchCount, Valid,
//            Err (only when JAM_TIMEOUT_EN is defined)
// Revision : 1.0 - initial release
// ============================================================================
interface jam_eval_scheduler_if;
  import jam_pkg::*;

  logic [IDX_W-1:0]  W;
  logic [IDX_W-1:0]  J;
  logic [COST_W-1:0] Cost;
  logic              Restart;
  logic              ev_wr_en;
  logic [IDX_W-1:0]  ev_wr_w;
  logic [IDX_W-1:0]  ev_wr_j;
  logic [COST_W-1:0] ev_wr_data;
  logic              ev_start;
  logic              ev_done;
  logic [SUM_W-1:0]  ev_min;
  logic [CNT_W-1:0]  ev_cnt;
  logic [SUM_W-1:0]  MinCost;
  logic [CNT_W-1:0]  MatchCount;
  logic              Valid;

`ifdef JAM_TIMEOUT_EN
  logic              Err;

  modport master (
    output W, J, ev_wr_en, ev_wr_w, ev_wr_j, ev_wr_data, ev_start,
           MinCost, MatchCount, Valid, Err,
    input  Cost, Restart, ev_done, ev_min, ev_cnt
  );

  modport slave (
    input  W, J, ev_wr_en, ev_wr_w, ev_wr_j, ev_wr_data, ev_start,
           MinCost, MatchCount, Valid, Err,
    output Cost, Restart, ev_done, ev_min, ev_cnt
  );
`else
  modport master (
    output W, J, ev_wr_en, ev_wr_w, ev_wr_j, ev_wr_data, ev_start,
           MinCost, MatchCount, Valid,
    input  Cost, Restart, ev_done, ev_min, ev_cnt
  );

  modport slave (
    input  W, J, ev_wr_en, ev_wr_w, ev_wr_j, ev_wr_data, ev_start,
           MinCost, MatchCount, Valid,
    output Cost, Restart, ev_done, ev_min, ev_cnt
  );
`endif

endinterface
`default_nettype wire

// File: rtl/jam_addr_raster.sv
`default_nettype none
// ============================================================================
// Module   : jam_addr_raster
// Purpose  : Worker/job raster counter. J advances every enabled cycle; on
//            J wrapping to 0, W advances. After (N-1,N-1) both wrap to 0.
// Ports    : clk, rst (async, active-high)
//            en   - advance one raster position
//            clr  - force back to (0,0); has priority over en
//            w, j - current worker / job index
//            last - high while (N-1,N-1) is being presented
// Revision : 1.0 - initial release
// ============================================================================
module jam_addr_raster #(
  parameter int N_IDX = 8,
  parameter int IDX_W = $clog2(N_IDX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [IDX_W-1:0] w,
  output logic [IDX_W-1:0] j,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IDX - 1);

  assign last = (w == LAST_IDX) && (j == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w <= '0;
      j <= '0;
    end else if (clr) begin
      w <= '0;
      j <= '0;
    end else if (en) begin
      if (j == LAST_IDX) begin
        j <= '0;
        w <= (w == LAST_IDX) ? '0 : w + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/jam_eval_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : jam_eval_scheduler
// Purpose  : Sequencer for the JAM flow. Rasters the 8x8 cost ROM, streams
//            each entry into the evaluator cost table with a one-cycle
//            address->data lag, starts the evaluator, waits for done and
//            latches MinCost/MatchCount with Valid held until Restart.
// Ports    : CLK  - rising-edge clock
//            RST  - asynchronous active-high reset
//            bus  - jam_eval_scheduler_if.master (ROM address/data,
//                   evaluator write/start/done, results, Restart)
// Config   : JAM_TIMEOUT_EN - adds a WAIT-state watchdog and the Err output
// Revision : 1.0 - initial release
// ============================================================================
module jam_eval_scheduler
  import jam_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  jam_eval_scheduler_if.master bus
);

  state_t state;
  state_t state_nxt;

  logic              ras_en;
  logic              ras_clr;
  logic              ras_last;
  logic [IDX_W-1:0]  addr_w;
  logic [IDX_W-1:0]  addr_j;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_w;
  logic [IDX_W-1:0]  wr_j;
  logic [COST_W-1:0] wr_data;
  logic              start;
  logic [SUM_W-1:0]  min_cost;
  logic [CNT_W-1:0]  match_cnt;
  logic              valid;
  logic              timeout;

  jam_addr_raster #(
    .N_IDX (N_IDX),
    .IDX_W (IDX_W)
  ) u_raster (
    .clk  (CLK),
    .rst  (RST),
    .en   (ras_en),
    .clr  (ras_clr),
    .w    (addr_w),
    .j    (addr_j),
    .last (ras_last)
  );

`ifdef JAM_TIMEOUT_EN
  logic [WD_W-1:0] wd_cnt;
  logic            err;

  // Cleared while in START so the first WAIT cycle reads 0; the timeout
  // fires on the edge that closes the TIMEOUT_CYC-th WAIT cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt <= '0;
    end else if (state == S_START) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // A real done in the same cycle beats the watchdog.
  assign timeout = (state == S_WAIT) && !bus.ev_done &&
                   (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end else if ((state == S_DONE) && bus.Restart) begin
      err <= 1'b0;
    end
  end

  assign bus.Err = err;
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and raster control
  always_comb begin
    state_nxt = state;
    ras_en    = 1'b0;
    ras_clr   = 1'b0;
    case (state)
      S_LOAD: begin
        ras_en = 1'b1;
        // The raster wraps to (0,0) on the same edge that leaves LOAD.
        if (ras_last) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.ev_done || timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.Restart) begin
          state_nxt = S_LOAD;
          ras_clr   = 1'b1;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Write-lag register, start pulse and result latches.
  // Every address presented in LOAD is written on the following cycle, so
  // the final (7,7) write lands in DRAIN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_en     <= 1'b0;
      wr_w      <= '0;
      wr_j      <= '0;
      wr_data   <= '0;
      start     <= 1'b0;
      min_cost  <= MAX_COST;
      match_cnt <= '0;
      valid     <= 1'b0;
    end else begin
      wr_en <= (state == S_LOAD);
      if (state == S_LOAD) begin
        wr_w    <= addr_w;
        wr_j    <= addr_j;
        wr_data <= bus.Cost;
      end

      start <= (state == S_DRAIN);

      if ((state == S_WAIT) && bus.ev_done) begin
        min_cost  <= bus.ev_min;
        match_cnt <= bus.ev_cnt;
        valid     <= 1'b1;
      end else if (timeout) begin
        min_cost  <= MAX_COST;
        match_cnt <= '0;
        valid     <= 1'b1;
      end else if ((state == S_DONE) && bus.Restart) begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.W          = addr_w;
  assign bus.J          = addr_j;
  assign bus.ev_wr_en   = wr_en;
  assign bus.ev_wr_w    = wr_w;
  assign bus.ev_wr_j    = wr_j;
  assign bus.ev_wr_data = wr_data;
  assign bus.ev_start   = start;
  assign bus.MinCost    = min_cost;
  assign bus.MatchCount = match_cnt;
  assign bus.Valid      = valid;

endmodule
`default_nettype wire

// File: tb/tb_jam_eval_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_jam_eval_scheduler
// Purpose  : Directed self-checking bench for jam_eval_scheduler. Models the
//            cost ROM as Cost = 8*W + J and plays the evaluator by hand.
// Config   : JAM_TIMEOUT_EN - also exercises the watchdog / Err output
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jam_eval_scheduler;
  import jam_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  int errors = 0;
  int checks = 0;

  jam_eval_scheduler_if bus ();

  jam_eval_scheduler dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  // Cost ROM: combinational, so the value is ready by the next rising edge.
  assign bus.Cost = COST_W'(8 * int'(bus.W) + int'(bus.J));

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "global timeout");
  end

  // Counts writes/start from the first cycle of a load (caller is positioned
  // in the cycle where (0,0) is presented). Bounded to 200 cycles.
  task automatic load_run(output int start_cyc, output int n_wr, output int bad_wr);
    start_cyc = -1;
    n_wr      = 0;
    bad_wr    = 0;
    for (int c = 1; c <= 200 && start_cyc < 0; c++) begin
      @(negedge CLK);
      if (bus.ev_wr_en === 1'b1) begin
        if ((int'(bus.ev_wr_w) * 8 + int'(bus.ev_wr_j)) != n_wr ||
            int'(bus.ev_wr_data) != n_wr) bad_wr++;
        n_wr++;
      end
      if (bus.ev_start === 1'b1) start_cyc = c;
    end
  endtask

  task automatic pulse_restart();
    @(negedge CLK);
    bus.Restart = 1'b1;
    @(negedge CLK);
    bus.Restart = 1'b0;
  endtask

  task automatic test_reset();
    RST         = 1'b1;
    bus.Restart = 1'b0;
    bus.ev_done = 1'b0;
    bus.ev_min  = '0;
    bus.ev_cnt  = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.W !== 3'd0 || bus.J !== 3'd0)
      $display("FAIL reset_addr: W=%0d J=%0d expected 0/0", bus.W, bus.J);
    if (bus.W !== 3'd0 || bus.J !== 3'd0) errors++;
    checks++;
    if (bus.ev_wr_en !== 1'b0 || bus.ev_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: wr_en=%b start=%b expected 0/0", bus.ev_wr_en, bus.ev_start);
    end
    checks++;
    if (bus.MinCost !== 10'd1023 || bus.MatchCount !== 4'd0 || bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: min=%0d cnt=%0d valid=%b expected 1023/0/0",
               bus.MinCost, bus.MatchCount, bus.Valid);
    end
  endtask

  // Release reset and check every cycle of the load phase.
  task automatic test_load();
    int pulses = 0;
    logic [2:0] ew, ej;
    logic       exp_wr;
    RST = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge CLK);
      exp_wr = (k <= 64);
      checks++;
      if (bus.ev_wr_en !== exp_wr) begin
        errors++;
        $display("FAIL load_wr_en cyc %0d: got %b expected %b", k, bus.ev_wr_en, exp_wr);
      end
      if (exp_wr) begin
        ew = 3'((k - 1) / 8);
        ej = 3'((k - 1) % 8);
        checks++;
        if (bus.ev_wr_w !== ew || bus.ev_wr_j !== ej || bus.ev_wr_data !== 7'(k - 1)) begin
          errors++;
          $display("FAIL load_wr_data cyc %0d: got w=%0d j=%0d d=%0d expected %0d/%0d/%0d",
                   k, bus.ev_wr_w, bus.ev_wr_j, bus.ev_wr_data, ew, ej, k - 1);
        end
      end
      ew = (k < 64) ? 3'(k / 8) : 3'd0;
      ej = (k < 64) ? 3'(k % 8) : 3'd0;
      checks++;
      if (bus.W !== ew || bus.J !== ej) begin
        errors++;
        $display("FAIL load_addr cyc %0d: got %0d/%0d expected %0d/%0d", k, bus.W, bus.J, ew, ej);
      end
      checks++;
      if (bus.ev_start !== (k == 65)) begin
        errors++;
        $display("FAIL load_start cyc %0d: got %b expected %b", k, bus.ev_start, (k == 65));
      end
      if (bus.ev_wr_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 64) begin
      errors++;
      $display("FAIL load_pulses: got %0d expected 64", pulses);
    end
  endtask

  // Positioned at cycle 66 (ev_start was cycle 65); done arrives at cycle 165.
  task automatic test_result();
    repeat (99) @(negedge CLK);
    bus.ev_done = 1'b1;
    bus.ev_min  = 10'd312;
    bus.ev_cnt  = 4'd3;
    checks++;
    if (bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL result_pre_valid: got %b expected 0", bus.Valid);
    end
    @(negedge CLK);
    bus.ev_done = 1'b0;
    bus.ev_min  = 10'd5;
    bus.ev_cnt  = 4'd9;
    checks++;
    if (bus.Valid !== 1'b1 || bus.MinCost !== 10'd312 || bus.MatchCount !== 4'd3) begin
      errors++;
      $display("FAIL result_latch: valid=%b min=%0d cnt=%0d expected 1/312/3",
               bus.Valid, bus.MinCost, bus.MatchCount);
    end
    for (int c = 1; c <= 50; c++) begin
      bus.ev_done = (c == 20);   // done outside WAIT must be ignored
      @(negedge CLK);
      checks++;
      if (bus.Valid !== 1'b1 || bus.MinCost !== 10'd312 || bus.MatchCount !== 4'd3 ||
          bus.ev_wr_en !== 1'b0 || bus.ev_start !== 1'b0) begin
        errors++;
        $display("FAIL result_hold cyc %0d: valid=%b min=%0d cnt=%0d wr=%b st=%b expected 1/312/3/0/0",
                 c, bus.Valid, bus.MinCost, bus.MatchCount, bus.ev_wr_en, bus.ev_start);
      end
    end
    bus.ev_done = 1'b0;
  endtask

  task automatic test_restart();
    int sc, nw, bw;
    pulse_restart();
    checks++;
    if (bus.Valid !== 1'b0 || bus.W !== 3'd0 || bus.J !== 3'd0 ||
        bus.MinCost !== 10'd312 || bus.MatchCount !== 4'd3) begin
      errors++;
      $display("FAIL restart_edge: valid=%b W=%0d J=%0d min=%0d cnt=%0d expected 0/0/0/312/3",
               bus.Valid, bus.W, bus.J, bus.MinCost, bus.MatchCount);
    end
    load_run(sc, nw, bw);
    checks++;
    if (sc !== 65 || nw !== 64 || bw !== 0) begin
      errors++;
      $display("FAIL restart_load: start_cyc=%0d writes=%0d bad=%0d expected 65/64/0", sc, nw, bw);
    end
    @(negedge CLK);
    bus.ev_done = 1'b1;
    bus.ev_min  = 10'd95;
    bus.ev_cnt  = 4'd1;
    @(negedge CLK);
    bus.ev_done = 1'b0;
    checks++;
    if (bus.Valid !== 1'b1 || bus.MinCost !== 10'd95 || bus.MatchCount !== 4'd1) begin
      errors++;
      $display("FAIL restart_result: valid=%b min=%0d cnt=%0d expected 1/95/1",
               bus.Valid, bus.MinCost, bus.MatchCount);
    end
  endtask

  task automatic test_reset_midload();
    int sc, nw, bw;
    bit found = 0;
    pulse_restart();
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge CLK);
      if (bus.W === 3'd3 && bus.J === 3'd5) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midload_reach: address (3,5) not seen, got %0d/%0d", bus.W, bus.J);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (bus.W !== 3'd0 || bus.J !== 3'd0 || bus.ev_wr_en !== 1'b0 || bus.ev_start !== 1'b0 ||
        bus.MinCost !== 10'd1023 || bus.MatchCount !== 4'd0 || bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL midload_async: W=%0d J=%0d wr=%b st=%b min=%0d cnt=%0d valid=%b expected 0/0/0/0/1023/0/0",
               bus.W, bus.J, bus.ev_wr_en, bus.ev_start, bus.MinCost, bus.MatchCount, bus.Valid);
    end
    @(negedge CLK);
    RST = 1'b0;
    load_run(sc, nw, bw);
    checks++;
    if (sc !== 65 || nw !== 64 || bw !== 0) begin
      errors++;
      $display("FAIL midload_reload: start_cyc=%0d writes=%0d bad=%0d expected 65/64/0", sc, nw, bw);
    end
  endtask

  // Starts in START (cycle 65 of the previous load).
  task automatic test_ignored();
    int sc, nw, bw;
    @(negedge CLK);                 // now in WAIT
    pulse_restart();                // Restart in WAIT: ignored
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.Valid !== 1'b0 || bus.ev_wr_en !== 1'b0 || bus.W !== 3'd0 || bus.J !== 3'd0) begin
        errors++;
        $display("FAIL ignore_restart cyc %0d: valid=%b wr=%b W=%0d J=%0d expected 0/0/0/0",
                 c, bus.Valid, bus.ev_wr_en, bus.W, bus.J);
      end
      @(negedge CLK);
    end
    bus.ev_done = 1'b1;
    bus.ev_min  = 10'd200;
    bus.ev_cnt  = 4'd5;
    @(negedge CLK);
    bus.ev_done = 1'b0;
    checks++;
    if (bus.Valid !== 1'b1 || bus.MinCost !== 10'd200 || bus.MatchCount !== 4'd5) begin
      errors++;
      $display("FAIL ignore_wait_done: valid=%b min=%0d cnt=%0d expected 1/200/5",
               bus.Valid, bus.MinCost, bus.MatchCount);
    end
    // Restart together with done in DONE, then done held through LOAD.
    bus.ev_done = 1'b1;
    bus.ev_min  = 10'd7;
    bus.ev_cnt  = 4'd9;
    pulse_restart();
    checks++;
    if (bus.Valid !== 1'b0 || bus.MinCost !== 10'd200 || bus.MatchCount !== 4'd5) begin
      errors++;
      $display("FAIL ignore_restart_wins: valid=%b min=%0d cnt=%0d expected 0/200/5",
               bus.Valid, bus.MinCost, bus.MatchCount);
    end
    load_run(sc, nw, bw);
    bus.ev_done = 1'b0;
    checks++;
    if (sc !== 65 || nw !== 64 || bw !== 0) begin
      errors++;
      $display("FAIL ignore_load_seq: start_cyc=%0d writes=%0d bad=%0d expected 65/64/0", sc, nw, bw);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.Valid !== 1'b0 || bus.MinCost !== 10'd200 || bus.MatchCount !== 4'd5) begin
      errors++;
      $display("FAIL ignore_load_done: valid=%b min=%0d cnt=%0d expected 0/200/5",
               bus.Valid, bus.MinCost, bus.MatchCount);
    end
    bus.ev_done = 1'b1;
    bus.ev_min  = 10'd1000;
    bus.ev_cnt  = 4'd15;
    @(negedge CLK);
    bus.ev_done = 1'b0;
    checks++;
    if (bus.Valid !== 1'b1 || bus.MinCost !== 10'd1000 || bus.MatchCount !== 4'd15) begin
      errors++;
      $display("FAIL ignore_full_width: valid=%b min=%0d cnt=%0d expected 1/1000/15",
               bus.Valid, bus.MinCost, bus.MatchCount);
    end
  endtask

`ifdef JAM_TIMEOUT_EN
  task automatic test_timeout();
    int sc, nw, bw;
    int waited = -1;
    checks++;
    if (bus.Err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_pre: got %b expected 0", bus.Err);
    end
    pulse_restart();
    load_run(sc, nw, bw);
    checks++;
    if (sc !== 65 || nw !== 64 || bw !== 0) begin
      errors++;
      $display("FAIL timeout_load: start_cyc=%0d writes=%0d bad=%0d expected 65/64/0", sc, nw, bw);
    end
    for (int c = 1; c <= 41000 && waited < 0; c++) begin
      @(negedge CLK);
      if (bus.Valid === 1'b1) waited = c;
    end
    checks++;
    if (waited !== 40401) begin
      errors++;
      $display("FAIL timeout_latency: valid after %0d cycles from start, expected 40401", waited);
    end
    checks++;
    if (bus.Err !== 1'b1 || bus.MinCost !== 10'd1023 || bus.MatchCount !== 4'd0) begin
      errors++;
      $display("FAIL timeout_result: err=%b min=%0d cnt=%0d expected 1/1023/0",
               bus.Err, bus.MinCost, bus.MatchCount);
    end
    pulse_restart();
    checks++;
    if (bus.Err !== 1'b0 || bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_clear: err=%b valid=%b expected 0/0", bus.Err, bus.Valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_result();
    test_restart();
    test_reset_midload();
    test_ignored();
`ifdef JAM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
